stopwatch_bcd: RTL and testbench

STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

---
 rtl/stopwatch_bcd.sv | 214 +++++++++++++++++++++
 tb/tb_stopwatch_bcd.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd.sv
// BCD stopwatch M:SS.CC counted from a 1 ms tick, with a missing-tick watchdog.
// Define STOPWATCH_LAP_HOLD_EN to enable the lap display-hold feature.
module stopwatch_bcd #(
    parameter int unsigned TICK_TIMEOUT = 50100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [7:0] cs_bcd,
    output logic       running,
    output logic       done,
    output logic       tick_err
);

    localparam int unsigned WDW = $clog2(TICK_TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_MAX = WDW'(TICK_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    state_t         state_q;
    state_t         state_n;
    logic [3:0]     sub_q;
    logic [3:0]     sub_n;
    logic [7:0]     cs_q;
    logic [7:0]     cs_n;
    logic [7:0]     sec_q;
    logic [7:0]     sec_n;
    logic [3:0]     min_q;
    logic [3:0]     min_n;
    logic [WDW-1:0] wd_q;
    logic [WDW-1:0] wd_n;
    logic           err_q;
    logic           err_n;
    logic           counted;
    logic           full;

    function automatic logic [3:0] dig_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    assign counted = (state_q == RUN) && tick;

    // Last tick of full scale: enter DONE instead of wrapping to 0:00.00.
    assign full = counted && (sub_q == 4'd9) && (cs_q == 8'h99)
               && (sec_q == 8'h59) && (min_q == 4'd9);

    always_comb begin
        state_n = state_q;
        if (clear) begin
            state_n = IDLE;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (!stop && start) begin
                        state_n = RUN;
                    end
                end
                RUN: begin
                    if (full) begin
                        state_n = DONE;
                    end else if (stop) begin
                        state_n = PAUSE;
                    end
                end
                DONE: begin
                    state_n = DONE;
                end
            endcase
        end
    end

    always_comb begin
        sub_n = sub_q;
        cs_n  = cs_q;
        sec_n = sec_q;
        min_n = min_q;
        if (clear) begin
            sub_n = '0;
            cs_n  = '0;
            sec_n = '0;
            min_n = '0;
        end else if (counted && !full) begin
            if (sub_q != 4'd9) begin
                sub_n = sub_q + 4'd1;
            end else begin
                sub_n = '0;
                cs_n[3:0] = dig_inc(cs_q[3:0]);
                if (cs_q[3:0] == 4'd9) begin
                    cs_n[7:4] = dig_inc(cs_q[7:4]);
                end
                if (cs_q == 8'h99) begin
                    sec_n[3:0] = dig_inc(sec_q[3:0]);
                    if (sec_q[3:0] == 4'd9) begin
                        sec_n[7:4] = (sec_q[7:4] == 4'd5) ? 4'd0
                                   : sec_q[7:4] + 4'd1;
                    end
                    if (sec_q == 8'h59) begin
                        min_n = dig_inc(min_q);
                    end
                end
            end
        end
    end

    always_comb begin
        wd_n  = wd_q;
        err_n = err_q;
        if (state_q != RUN) begin
            if (state_n == RUN) begin
                wd_n = '0;
            end
        end else if (counted) begin
            wd_n = '0;
        end else if (wd_q != WD_MAX) begin
            wd_n = wd_q + WDW'(1);
        end
        if (state_q == RUN && wd_n == WD_MAX) begin
            err_n = 1'b1;
        end
        if (clear) begin
            err_n = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sub_q   <= '0;
            cs_q    <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            sub_q   <= sub_n;
            cs_q    <= cs_n;
            sec_q   <= sec_n;
            min_q   <= min_n;
            wd_q    <= wd_n;
            err_q   <= err_n;
        end
    end

    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign tick_err = err_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic       hold_q;
    logic       hold_n;
    logic [3:0] hmin_q;
    logic [3:0] hmin_n;
    logic [7:0] hsec_q;
    logic [7:0] hsec_n;
    logic [7:0] hcs_q;
    logic [7:0] hcs_n;

    // Snapshot is the live time as seen in the lap cycle, before any tick.
    always_comb begin
        hold_n = hold_q;
        hmin_n = hmin_q;
        hsec_n = hsec_q;
        hcs_n  = hcs_q;
        if (state_n == IDLE || state_n == DONE) begin
            hold_n = 1'b0;
        end else if (state_q == RUN && lap) begin
            hold_n = !hold_q;
            if (!hold_q) begin
                hmin_n = min_q;
                hsec_n = sec_q;
                hcs_n  = cs_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            hmin_q <= '0;
            hsec_q <= '0;
            hcs_q  <= '0;
        end else begin
            hold_q <= hold_n;
            hmin_q <= hmin_n;
            hsec_q <= hsec_n;
            hcs_q  <= hcs_n;
        end
    end

    assign min_bcd = hold_q ? hmin_q : min_q;
    assign sec_bcd = hold_q ? hsec_q : sec_q;
    assign cs_bcd  = hold_q ? hcs_q  : cs_q;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign min_bcd = min_q;
    assign sec_bcd = sec_q;
    assign cs_bcd  = cs_q;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: tick-count model compared every cycle,
// plus literal checkpoints that pin the model.
module tb_stopwatch_bcd;

    localparam int TO   = 100;
    localparam int MAXT = 599999;
    localparam int PRE  = 599990;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [7:0] cs_bcd;
    logic       running;
    logic       done;
    logic       tick_err;

    stopwatch_bcd #(.TICK_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .start(start),
        .stop(stop), .clear(clear), .lap(lap),
        .min_bcd(min_bcd), .sec_bcd(sec_bcd), .cs_bcd(cs_bcd),
        .running(running), .done(done), .tick_err(tick_err)
    );

    always #10 clk = ~clk;

    // Model: time is just the number of counted ticks.
    int ms = S_IDLE;
    int mt = 0;
    int held = 0;
    int since = 0;
    bit hold = 0;
    bit err = 0;
    bit do_preload = 0;
    bit chk_en = 0;

    int nvec = 0;
    int nbad = 0;
    int lit_seq = 0;
    int lit_done = 0;
    string lit_name = "";
    logic [22:0] lit_exp = '0;

    function automatic logic [19:0] bcd(input int t);
        int c, s, m;
        c = (t / 10) % 100;
        s = (t / 1000) % 60;
        m = t / 60000;
        return {4'(m), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            ms = S_IDLE; mt = 0; err = 0; since = 0; hold = 0; held = 0;
        end else if (clear) begin
            ms = S_IDLE; mt = 0; err = 0; hold = 0;
        end else begin
            if (do_preload) mt = PRE;
            case (ms)
                S_IDLE, S_PAUSE: begin
                    if (start && !stop) begin
                        ms = S_RUN;
                        since = 0;
                    end
                end
                S_RUN: begin
`ifdef STOPWATCH_LAP_HOLD_EN
                    if (lap) begin
                        if (!hold) held = mt;
                        hold = !hold;
                    end
`endif
                    if (tick) begin
                        since = 0;
                        if (mt == MAXT) begin
                            ms = S_DONE;
                            hold = 0;
                        end else begin
                            mt++;
                        end
                    end else begin
                        since++;
                        if (since >= TO) err = 1;
                    end
                    if (ms == S_RUN && stop) ms = S_PAUSE;
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string nm, input logic [22:0] act,
                         input logic [22:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            if (nbad <= 30)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    initial forever begin
        logic [22:0] act;
        logic [22:0] exp;
        @(negedge clk);
        #1;
        act = {min_bcd, sec_bcd, cs_bcd, running, done, tick_err};
        if (chk_en) begin
            exp = {bcd(hold ? held : mt), ms == S_RUN, ms == S_DONE, err};
            check("model", act, exp);
        end
        if (lit_seq != lit_done) begin
            lit_done = lit_seq;
            check(lit_name, act, lit_exp);
        end
    end

    task automatic cyc(input logic t, input logic s, input logic p,
                       input logic c, input logic l);
        @(negedge clk);
        tick = t; start = s; stop = p; clear = c; lap = l;
    endtask

    task automatic ticks(input int n);
        repeat (n) cyc(1, 0, 0, 0, 0);
    endtask

    task automatic lit(input string nm, input logic [22:0] e);
        cyc(0, 0, 0, 0, 0);
        lit_name = nm;
        lit_exp = e;
        lit_seq++;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_en = 1;
        lit("reset", {4'h0, 8'h00, 8'h00, 3'b000});
        rst_n = 1'b1;

        cyc(0, 1, 0, 0, 0);
        ticks(250);
        lit("run250", {4'h0, 8'h00, 8'h25, 3'b100});

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(1000);
        lit("one_sec", {4'h0, 8'h01, 8'h00, 3'b100});
        cyc(0, 1, 1, 1, 0);
        lit("clr_wins", {4'h0, 8'h00, 8'h00, 3'b000});
        cyc(0, 1, 0, 0, 0);
        ticks(29);
        cyc(1, 0, 1, 0, 0);
        lit("stop_tick", {4'h0, 8'h00, 8'h03, 3'b000});
        cyc(1, 1, 1, 0, 0);
        lit("stop_wins", {4'h0, 8'h00, 8'h03, 3'b000});
        cyc(1, 1, 0, 0, 0);
        ticks(10);
        lit("resume", {4'h0, 8'h00, 8'h04, 3'b100});

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        ticks(60000);
        cyc(0, 0, 1, 0, 0);
        ticks(5);
        lit("one_min", {4'h1, 8'h00, 8'h00, 3'b000});
        cyc(0, 1, 0, 0, 0);
        ticks(10);
        lit("min_cs1", {4'h1, 8'h00, 8'h01, 3'b100});

        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 0, 0, 0);
        repeat (99) cyc(0, 0, 0, 0, 0);
        lit("wd_99", {4'h0, 8'h00, 8'h00, 3'b100});
        lit("wd_100", {4'h0, 8'h00, 8'h00, 3'b101});
        ticks(20);
        lit("err_cnt", {4'h0, 8'h00, 8'h02, 3'b101});
        cyc(0, 0, 0, 1, 0);
        lit("err_clr", {4'h0, 8'h00, 8'h00, 3'b000});

        // Preload 9:59.99 (sub-count 0) in IDLE instead of 599990 ticks.
        cyc(0, 0, 0, 0, 0);
        #2;
        force dut.min_q = 4'h9;
        force dut.sec_q = 8'h59;
        force dut.cs_q = 8'h99;
        do_preload = 1;
        #1;
        release dut.min_q;
        release dut.sec_q;
        release dut.cs_q;
        cyc(0, 1, 0, 0, 0);
        do_preload = 0;
        ticks(9);
        lit("pre_full", {4'h9, 8'h59, 8'h99, 3'b100});
        ticks(1);
        lit("done", {4'h9, 8'h59, 8'h99, 3'b010});
        ticks(20);
        cyc(0, 1, 0, 0, 0);
        lit("done_hold", {4'h9, 8'h59, 8'h99, 3'b010});
        cyc(0, 0, 0, 1, 0);
        lit("done_clr", {4'h0, 8'h00, 8'h00, 3'b000});

        cyc(0, 1, 0, 0, 0);
        ticks(100);
        cyc(0, 0, 0, 0, 1);
        ticks(100);
`ifdef STOPWATCH_LAP_HOLD_EN
        lit("lap_on", {4'h0, 8'h00, 8'h10, 3'b100});
`else
        lit("lap_off", {4'h0, 8'h00, 8'h20, 3'b100});
`endif
        cyc(0, 0, 0, 0, 1);
        lit("lap_rel", {4'h0, 8'h00, 8'h20, 3'b100});

        ticks(50);
        #3;
        rst_n = 1'b0;
        #2;
        check("async_rst", {min_bcd, sec_bcd, cs_bcd, running, done, tick_err},
              {4'h0, 8'h00, 8'h00, 3'b000});
        repeat (2) cyc(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        ticks(20);
        lit("rst_idle", {4'h0, 8'h00, 8'h00, 3'b000});
        cyc(0, 1, 0, 0, 0);
        ticks(10);
        lit("rst_run", {4'h0, 8'h00, 8'h01, 3'b100});

        repeat (2) cyc(0, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
